// File: rtl/vector_sequencer_pkg.sv
// rtl/vector_sequencer_pkg.sv - shared state encoding for the vector sequencer
// Contents: state_t (sequencer FSM states) and STATE_W (its encoded width).
package vector_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/vector_sequencer_if.sv
// rtl/vector_sequencer_if.sv - vector load, run control, DUT and result signals
// master: drives vector writes, num_vec/start/abort and dut_out; reads dut_in and results.
// slave:  the sequencer side of the same signals.
interface vector_sequencer_if #(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int WAIT_W = 8
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [IN_W-1:0]   wr_stim;
  logic [OUT_W-1:0]  wr_exp;
  logic [WAIT_W-1:0] wr_wait;
  logic [AW:0]       num_vec;
  logic              start;
  logic              abort;
  logic [IN_W-1:0]   dut_in;
  logic [OUT_W-1:0]  dut_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [FW-1:0]     fail_count;
  logic              fail_valid;
  logic [AW-1:0]     first_fail_idx;

  modport master (
    output wr_en, wr_addr, wr_stim, wr_exp, wr_wait, num_vec, start, abort, dut_out,
    input  dut_in, busy, done, pass, fail_count, fail_valid, first_fail_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_stim, wr_exp, wr_wait, num_vec, start, abort, dut_out,
    output dut_in, busy, done, pass, fail_count, fail_valid, first_fail_idx
  );

endinterface

// File: rtl/vector_mem.sv
// rtl/vector_mem.sv - vector store: synchronous write, combinational read, no reset
// clk: write clock; we/waddr/wstim/wexp/wwait: write port;
// raddr: read index; rstim/rexp/rwait: entry at raddr.
module vector_mem #(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 4,
  parameter int WAIT_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [IN_W-1:0]          wstim,
  input  logic [OUT_W-1:0]         wexp,
  input  logic [WAIT_W-1:0]        wwait,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [IN_W-1:0]          rstim,
  output logic [OUT_W-1:0]         rexp,
  output logic [WAIT_W-1:0]        rwait
);

  localparam int EW = IN_W + OUT_W + WAIT_W;

  // Contents are undefined until written; only control state is reset.
  logic [EW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= {wstim, wexp, wwait};
    end
  end

  assign {rstim, rexp, rwait} = mem_q[raddr];

endmodule

// File: rtl/vector_sequencer.sv
// rtl/vector_sequencer.sv - drives stored vectors into a DUT and checks its responses
// clk/rst: clock and asynchronous active-high reset.
// bus (slave): vector writes, num_vec/start/abort, dut_in/dut_out, busy/done/pass and
// fail_count/fail_valid/first_fail_idx results.
module vector_sequencer
  import vector_sequencer_pkg::*;
#(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int WAIT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  vector_sequencer_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [AW:0]       nvec_q, nvec_d;
  logic [IN_W-1:0]   dut_in_q, dut_in_d;
  logic [FW-1:0]     fail_count_q, fail_count_d;
  logic              fail_valid_q, fail_valid_d;
  logic [AW-1:0]     first_fail_idx_q, first_fail_idx_d;

  logic              idle_like;
  logic              mem_we;
  logic              last_vec;
  logic [IN_W-1:0]   rd_stim;
  logic [OUT_W-1:0]  rd_exp;
  logic [WAIT_W-1:0] rd_wait;

  // The store is only writable while no run is in flight, so a run always
  // sees the vectors that were present at its start edge.
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign mem_we    = bus.wr_en && idle_like;
  assign last_vec  = ({1'b0, idx_q} == (nvec_q - (AW+1)'(1)));

  vector_mem #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .WAIT_W (WAIT_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.wr_addr),
    .wstim (bus.wr_stim),
    .wexp  (bus.wr_exp),
    .wwait (bus.wr_wait),
    .raddr (idx_q),
    .rstim (rd_stim),
    .rexp  (rd_exp),
    .rwait (rd_wait)
  );

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    cnt_d            = cnt_q;
    nvec_d           = nvec_q;
    dut_in_d         = dut_in_q;
    fail_count_d     = fail_count_q;
    fail_valid_d     = fail_valid_q;
    first_fail_idx_d = first_fail_idx_q;

    // abort freezes everything except the state, including a CHECK in flight.
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            fail_count_d     = '0;
            fail_valid_d     = 1'b0;
            first_fail_idx_d = '0;
            idx_d            = '0;
            nvec_d           = (bus.num_vec > DEPTH_N) ? DEPTH_N : bus.num_vec;
            state_d          = (bus.num_vec == '0) ? ST_DONE : ST_APPLY;
          end
        end
        ST_APPLY: begin
          dut_in_d = rd_stim;
          cnt_d    = rd_wait;
          state_d  = ST_WAIT;
        end
        ST_WAIT: begin
          // Counting down through zero gives wait+1 cycles in this state.
          if (cnt_q == '0) begin
            state_d = ST_CHECK;
          end else begin
            cnt_d = cnt_q - WAIT_W'(1);
          end
        end
        ST_CHECK: begin
          if (bus.dut_out != rd_exp) begin
            fail_count_d = fail_count_q + FW'(1);
            if (!fail_valid_q) begin
              fail_valid_d     = 1'b1;
              first_fail_idx_d = idx_q;
            end
          end
          if (last_vec) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = ST_APPLY;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      cnt_q            <= '0;
      nvec_q           <= '0;
      dut_in_q         <= '0;
      fail_count_q     <= '0;
      fail_valid_q     <= 1'b0;
      first_fail_idx_q <= '0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      cnt_q            <= cnt_d;
      nvec_q           <= nvec_d;
      dut_in_q         <= dut_in_d;
      fail_count_q     <= fail_count_d;
      fail_valid_q     <= fail_valid_d;
      first_fail_idx_q <= first_fail_idx_d;
    end
  end

  // Status decodes straight from registers so an async reset clears them at once.
  assign bus.dut_in         = dut_in_q;
  assign bus.busy           = (state_q == ST_APPLY) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
  assign bus.done           = (state_q == ST_DONE);
  assign bus.pass           = (state_q == ST_DONE) && (fail_count_q == '0);
  assign bus.fail_count     = fail_count_q;
  assign bus.fail_valid     = fail_valid_q;
  assign bus.first_fail_idx = first_fail_idx_q;

endmodule

// File: doc/vector_sequencer.md
# vector_sequencer

Synthesizable self-test controller that sequences a device-under-test through a stored list of input vectors. For each vector it drives the stimulus, holds it for a programmed dwell time, then compares the DUT output against an expected value. It moves the timed drive-and-check flow of a testbench into hardware, so a DUT can be checked on the board or in a single top-level simulation with a pass/fail summary.

## Interface
Parameters:
- IN_W, 4, stimulus width (DUT input)
- OUT_W, 4, DUT output width
- DEPTH, 16, vector store entries (power of 2, ≥2)
- WAIT_W, 8, dwell counter width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- wr_en  in  1  write one vector entry (ignored while busy)
- wr_addr  in  $clog2(DEPTH)  entry index
- wr_stim  in  IN_W  stimulus value
- wr_exp  in  OUT_W  expected DUT output
- wr_wait  in  WAIT_W  dwell cycles
- num_vec  in  $clog2(DEPTH)+1  vectors to run; sampled on start; values above DEPTH are clamped to DEPTH
- start  in  1  begin a run (accepted only in IDLE or DONE)
- abort  in  1  stop the run and return to IDLE
- dut_in  out  IN_W  registered stimulus to the DUT
- dut_out  in  OUT_W  DUT response
- busy  out  1  high in APPLY/WAIT/CHECK
- done  out  1  high in DONE until the next start, abort or rst
- pass  out  1  done && fail_count==0
- fail_count  out  $clog2(DEPTH+1)  mismatches in the current/last run
- fail_valid  out  1  at least one mismatch recorded
- first_fail_idx  out  $clog2(DEPTH)  index of the first mismatching vector

## Operation
- States: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE/DONE with start:
  - Clear fail_count, fail_valid and first_fail_idx; set idx=0; latch the clamped num_vec.
  - num_vec==0 → DONE (pass=1); otherwise → APPLY.
- APPLY: dut_in←stim[idx], cnt←wait[idx], then → WAIT.
- WAIT:
  - cnt==0 → CHECK; otherwise cnt←cnt−1.
  - WAIT lasts wait[idx]+1 cycles.
- CHECK: compare dut_out with exp[idx] in this cycle.
  - On mismatch: fail_count+1. On the first mismatch also set fail_valid=1 and first_fail_idx=idx.
  - idx==num_vec−1 → DONE; otherwise idx+1 → APPLY.
- DONE: hold results and dut_in. start begins a new run.
- abort in any state → IDLE next edge.
  - done=0; results keep their last values; dut_in holds.
  - abort takes priority over start in the same cycle.
- wr_en while busy is ignored. Writes in IDLE/DONE take effect next cycle. A write in the same cycle as start is applied, and the run uses the new data.
- Vector storage is not reset; only control and result registers are.

## Timing
- Reset values: state=IDLE; dut_in=0, busy=0, done=0, pass=0, fail_count=0, fail_valid=0, first_fail_idx=0.
- Per vector: 1 (APPLY) + wait+1 (WAIT) + 1 (CHECK) = wait+3 cycles.
- dut_in changes on the edge ending APPLY. dut_out is sampled in CHECK after dut_in has been stable for wait+2 cycles.
- Total run length: sum(wait_i+3) cycles from the start edge to done rising. done rises on the edge ending the last CHECK.
- rst asserted mid-run: every output returns to its reset value immediately, without waiting for a clock edge.
- fail_count cannot overflow: its maximum value is DEPTH.

## Structure
- Package vector_sequencer_pkg: state enum (IDLE, APPLY, WAIT, CHECK, DONE) and state-width localparam.
- Sub-module vector_mem: DEPTH×(IN_W+OUT_W+WAIT_W) register file, synchronous write, combinational read by idx, no reset.
- Top: FSM, idx/cnt counters, result registers.

## Test plan
- Identity check: DUT is a registered buffer. Load 3 vectors with stim=1,2,3, exp=1,2,3 and wait=0,2,5. Start → done after 16 cycles, pass=1, fail_count=0.
- Mismatch recording: same setup with exp[1]=7 and exp[2]=9. Required: fail_count=2, fail_valid=1, first_fail_idx=1, pass=0.
- Zero vectors: start with num_vec=0 → done=1 and pass=1 on the next edge; dut_in stays 0.
- Abort and rerun: abort in WAIT of vector 1 → IDLE next edge, busy=0, done=0. A following start reruns from idx 0.
- Async reset and write lockout: assert rst mid-CHECK → all outputs at reset values before the next edge. Separately, wr_en while busy leaves the stored entry unchanged on a later readback run.
- Clamping: num_vec=DEPTH+1 runs exactly DEPTH vectors. With all exp wrong, fail_count=DEPTH.
